bram_stream_reader: RTL and testbench

Read-side client for the 256x4096 dual-port activation/weight BRAM. It accepts a (start address, length) read command and drives one BRAM port with read-only accesses. It absorbs the BRAM's 1-cycle registered read latency and delivers the words, in address order, on a valid/ready stream with a last flag, holding full throughput under arbitrary backpressure. It sits between a BRAM port and the downstream consumer, e.g. a systolic array feeder or a DMA-out path.

---
 rtl/bram_stream_reader_pkg.sv | 7 +
 rtl/bram_stream_reader_if.sv | 29 ++
 rtl/bram_stream_reader_fifo.sv | 46 ++++
 rtl/bram_stream_reader.sv | 69 ++++++
 tb/tb_bram_stream_reader.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared BRAM widths, output buffer depth and FSM states
package bram_stream_reader_pkg;
   localparam int DATA_WIDTH = 256;
   localparam int ADDR_WIDTH = 12;
   localparam int FIFO_DEPTH = 4;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: command, BRAM port and output stream signals of the reader
interface bram_stream_reader_if
   import bram_stream_reader_pkg::*;
#(
   parameter int DW = DATA_WIDTH,
   parameter int AW = ADDR_WIDTH
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [AW-1:0] cmd_len;
   logic          bram_en;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_dout;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, bram_dout, out_ready,
      output cmd_ready, bram_en, bram_we, bram_addr, out_valid, out_data, out_last, busy
   );
   modport master (
      output cmd_valid, cmd_addr, cmd_len, bram_dout, out_ready,
      input  cmd_ready, bram_en, bram_we, bram_addr, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/bram_stream_reader_fifo.sv
// stream_fifo: synchronous FIFO whose head entry sits in output flops
module stream_fifo
   import bram_stream_reader_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH + 1,
   parameter int DEPTH = FIFO_DEPTH,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wp, r_rp;
   logic [CW-1:0]    r_cnt;
   logic             w_adv, w_rpop, w_bypass, w_rpush;
   // head refills from the ring first; an empty ring lets a push go straight to the head
   assign w_adv    = !o_valid || i_pop;
   assign w_rpop   = w_adv && r_cnt != '0;
   assign w_bypass = w_adv && r_cnt == '0 && i_push;
   assign w_rpush  = i_push && !w_bypass;
   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_adv) o_valid <= w_rpop || w_bypass;
         if (w_rpop) o_data <= r_mem[r_rp];
         else if (w_bypass) o_data <= i_data;
         if (w_rpush) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_rpop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + CW'(w_rpush) - CW'(w_rpop);
      end
   end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a BRAM address range and streams it out over valid/ready with last
module bram_stream_reader
   import bram_stream_reader_pkg::*;
#(
   parameter int DW = DATA_WIDTH,
   parameter int AW = ADDR_WIDTH,
   parameter int DEPTH = FIFO_DEPTH,
   localparam int OW = $clog2(DEPTH) + 1
) (
   input logic                 clk,
   input logic                 rst,
   bram_stream_reader_if.slave bus
);
   state_t        r_state, w_next;
   logic [AW-1:0] r_ptr, r_rem;
   logic [OW-1:0] r_out;
   logic          r_pv, r_plast, w_issue, w_final, w_pop;
   logic [DW:0]   w_head;
   assign w_pop = bus.out_valid && bus.out_ready;
   always_comb begin
      w_issue       = r_state == ISSUE && r_out != OW'(DEPTH);
      w_final       = w_issue && r_rem == '0;
      bus.cmd_ready = r_state == IDLE;
      bus.busy      = r_state != IDLE;
      bus.bram_en   = w_issue;
      bus.bram_we   = 1'b0;
      bus.bram_addr = r_ptr;
      w_next        = r_state;
      if (r_state == IDLE && bus.cmd_valid) w_next = ISSUE;
      if (w_final) w_next = DRAIN;
      if (r_state == DRAIN && w_pop && bus.out_last) w_next = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   // outstanding covers reads in flight and words buffered, so the FIFO can never overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr   <= '0;
         r_rem   <= '0;
         r_out   <= '0;
         r_pv    <= 1'b0;
         r_plast <= 1'b0;
      end else begin
         r_pv    <= w_issue;
         r_plast <= w_final;
         r_out   <= r_out + OW'(w_issue) - OW'(w_pop);
         if (bus.cmd_valid && bus.cmd_ready) begin
            r_ptr <= bus.cmd_addr;
            r_rem <= bus.cmd_len;
         end else if (w_issue) begin
            r_ptr <= r_ptr + 1'b1;
            r_rem <= r_rem - 1'b1;
         end
      end
   end
   stream_fifo #(.WIDTH(DW + 1), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_pv),
      .i_data  ({r_plast, bus.bram_dout}),
      .i_pop   (w_pop),
      .o_valid (bus.out_valid),
      .o_data  (w_head)
   );
   assign bus.out_last = w_head[DW];
   assign bus.out_data = w_head[DW-1:0];
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed commands checked against a queue model of the expected reads and words
`timescale 1ns/1ps
module tb_bram_stream_reader;
   import bram_stream_reader_pkg::*;
   typedef struct {logic [11:0] a; logic l;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   bram_stream_reader_if bif();
   bram_stream_reader dut (.clk(clk), .rst(rst), .bus(bif.slave));
   always #5 clk = ~clk;

   function automatic logic [255:0] word(input logic [11:0] a);
      return {116'd0, 12'(a * 3 + 7), 116'd0, a};
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) if (bif.bram_en) bif.bram_dout <= word(bif.bram_addr);

   exp_t        pop_q[$];
   logic [11:0] iss_q[$];
   logic [11:0] popped[$];
   exp_t        e_cur;
   int          outst = 0;
   int          max_out = 0;
   logic        hold = 1'b0;
   logic [255:0] prev_d;
   logic        prev_l;
   always @(negedge clk) begin
      if (rst) begin
         pop_q.delete();
         iss_q.delete();
         outst = 0;
         hold = 1'b0;
      end else begin
         if (bif.cmd_valid && bif.cmd_ready)
            for (int k = 0; k <= int'(bif.cmd_len); k++) begin
               iss_q.push_back(bif.cmd_addr + 12'(k));
               pop_q.push_back('{bif.cmd_addr + 12'(k), k == int'(bif.cmd_len)});
            end
         check("busy", bif.busy, !bif.cmd_ready);
         check("bram_we", bif.bram_we, 0);
         check("outst_le_depth", outst <= FIFO_DEPTH, 1);
         if (outst == FIFO_DEPTH) check("en_at_full", bif.bram_en, 0);
         if (bif.bram_en) begin
            check("rd_pending", iss_q.size() > 0, 1);
            if (iss_q.size() > 0) check("rd_addr", bif.bram_addr, iss_q.pop_front());
         end
         if (hold) begin
            check("hold_valid", bif.out_valid, 1);
            check("hold_data", bif.out_data, prev_d);
            check("hold_last", bif.out_last, prev_l);
         end
         if (bif.out_valid && bif.out_ready) begin
            check("pop_pending", pop_q.size() > 0, 1);
            if (pop_q.size() > 0) begin
               e_cur = pop_q.pop_front();
               check("out_data", bif.out_data, word(e_cur.a));
               check("out_last", bif.out_last, e_cur.l);
               popped.push_back(bif.out_data[11:0]);
            end
         end
         outst += int'(bif.bram_en) - int'(bif.out_valid && bif.out_ready);
         if (outst > max_out) max_out = outst;
         hold   = bif.out_valid && !bif.out_ready;
         prev_d = bif.out_data;
         prev_l = bif.out_last;
      end
   end

   task automatic check_reset(input string t);
      check({t, "_cmd_ready"}, bif.cmd_ready, 1);
      check({t, "_bram_en"}, bif.bram_en, 0);
      check({t, "_bram_we"}, bif.bram_we, 0);
      check({t, "_bram_addr"}, bif.bram_addr, 0);
      check({t, "_out_valid"}, bif.out_valid, 0);
      check({t, "_out_last"}, bif.out_last, 0);
      check({t, "_out_data"}, bif.out_data, 0);
      check({t, "_busy"}, bif.busy, 0);
   endtask

   task automatic run_cmd(input logic [11:0] a, input logic [11:0] l, input int mode,
                          output int cyc, output int s);
      int c = 1;
      s = popped.size();
      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b1;
      bif.cmd_addr  = a;
      bif.cmd_len   = l;
      bif.out_ready = (mode == 0);
      @(negedge clk);
      check("cmd_accept", bif.cmd_ready, 1);
      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b0;
      while (c < 6000) begin
         @(negedge clk);
         if (bif.cmd_ready) break;
         @(posedge clk);
         #1;
         bif.out_ready = (mode == 0) ? 1'b1 : ((c % 24) < 10 ? 1'b0 : 1'($urandom_range(0, 1)));
         c++;
      end
      check("done_in_budget", c < 6000, 1);
      check("queues_drained", pop_q.size() + iss_q.size(), 0);
      cyc = c;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, s;
      bif.cmd_valid = 1'b0;
      bif.cmd_addr  = '0;
      bif.cmd_len   = '0;
      bif.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("por");
      @(posedge clk);
      #1 rst = 1'b0;

      s = popped.size();
      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b1;
      bif.cmd_addr  = 12'h010;
      bif.cmd_len   = 12'd0;
      @(negedge clk);
      check("s_accept", bif.cmd_ready, 1);
      @(posedge clk);
      #1 bif.cmd_valid = 1'b0;
      @(negedge clk);
      check("s_en_t1", bif.bram_en, 1);
      check("s_addr_t1", bif.bram_addr, 12'h010);
      check("s_ready_t1", bif.cmd_ready, 0);
      @(negedge clk);
      check("s_en_t2", bif.bram_en, 0);
      check("s_valid_t2", bif.out_valid, 0);
      @(negedge clk);
      check("s_valid_t3", bif.out_valid, 1);
      check("s_last_t3", bif.out_last, 1);
      check("s_data_lo_t3", bif.out_data[15:0], 16'h0010);
      @(negedge clk);
      check("s_ready_t4", bif.cmd_ready, 1);
      check("s_valid_t4", bif.out_valid, 0);
      check("s_count", popped.size() - s, 1);

      run_cmd(12'h100, 12'd15, 0, cyc, s);
      check("st_cycles", cyc, 19);
      check("st_count", popped.size() - s, 16);
      check("st_first", popped[s], 12'h100);
      check("st_final", popped[popped.size() - 1], 12'h10F);

      run_cmd(12'hFFE, 12'd3, 0, cyc, s);
      check("wr_cycles", cyc, 7);
      check("wr_count", popped.size() - s, 4);
      check("wr_first", popped[s], 12'hFFE);
      check("wr_third", popped[s + 2], 12'h000);
      check("wr_final", popped[popped.size() - 1], 12'h001);

      run_cmd(12'h300, 12'd31, 1, cyc, s);
      check("bp_count", popped.size() - s, 32);
      check("bp_max_outst", max_out, 4);
      check("bp_first", popped[s], 12'h300);
      check("bp_final", popped[popped.size() - 1], 12'h31F);

      run_cmd(12'h800, 12'd4095, 0, cyc, s);
      check("fm_cycles", cyc, 4099);
      check("fm_count", popped.size() - s, 4096);
      check("fm_first", popped[s], 12'h800);
      check("fm_final", popped[popped.size() - 1], 12'h7FF);

      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b1;
      bif.cmd_addr  = 12'h040;
      bif.cmd_len   = 12'd63;
      bif.out_ready = 1'b1;
      @(posedge clk);
      #1 bif.cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset("mid");
      run_cmd(12'h020, 12'd1, 0, cyc, s);
      check("mr_cycles", cyc, 5);
      check("mr_count", popped.size() - s, 2);
      check("mr_first", popped[s], 12'h020);
      check("mr_final", popped[popped.size() - 1], 12'h021);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
